// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding selects, M-stage FSM states and the M control bundle.
package pipe_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = 8'hFF;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MEMWAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic [4:0] dest;
    } mctl_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one ID source register against the in-flight E and M destinations.
module hazard_cmp
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic       evalid,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] edest,
    input  logic       mvalid,
    input  logic       mwreg,
    input  logic [4:0] mdest,
    output logic       e_hit,
    output logic       m_hit,
    output logic       e_is_load
);

    // Writes to r0 are architecturally discarded, so they never match.
    assign e_hit     = use_src & evalid & ewreg & (edest != REG_ZERO) & (src == edest);
    assign m_hit     = use_src & mvalid & mwreg & (mdest != REG_ZERO) & (src == mdest);
    assign e_is_load = e_hit & em2reg;

endmodule

// File: rtl/exemem_hazard_stage.sv
// EXE/MEM pipeline register with memory-wait FSM, RAW hazard detection and forwarding.
// Optional forwarding is enabled by defining EXEMEM_FWD_EN.
module exemem_hazard_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 8,
    parameter int unsigned DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          evalid,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic          ewmem,
    input  logic [4:0]    edestReg,
    input  logic [DW-1:0] ealu,
    input  logic [DW-1:0] eqb,
    input  logic [4:0]    drs,
    input  logic [4:0]    drt,
    input  logic          duse_rs,
    input  logic          duse_rt,
    input  logic          mem_rdy,
    output logic          mvalid,
    output logic          mwreg,
    output logic          mm2reg,
    output logic          mwmem,
    output logic [4:0]    mdestReg,
    output logic [DW-1:0] malu,
    output logic [DW-1:0] mqb,
    output logic          stall_id,
    output logic          e_hold,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          mem_timeout
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    mctl_t            m_q;
    logic [DW-1:0]    malu_q, mqb_q;
    logic             timeout_q;
    logic             m_mem, capture;

    logic rs_e_hit, rs_m_hit, rs_e_load;
    logic rt_e_hit, rt_m_hit, rt_e_load;
    logic load_use, nofwd_raw, m_load_stall;

    assign m_mem = m_q.valid & (m_q.m2reg | m_q.wmem);

    // Next-state, wait counter and E-hold decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        e_hold   = 1'b0;
        case (state)
            S_RUN: begin
                if (m_mem & ~mem_rdy) begin
                    state_nx = S_MEMWAIT;
                    cnt_nx   = CNT_W'(1);
                    e_hold   = 1'b1;
                end else begin
                    cnt_nx = '0;
                end
            end
            S_MEMWAIT: begin
                e_hold = 1'b1;
                if (mem_rdy) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else if (cnt != CNT_SAT) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // The E bundle advances on every edge that leaves the FSM in RUN.
    assign capture = (state_nx == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            cnt       <= '0;
            timeout_q <= 1'b0;
            m_q       <= '0;
            malu_q    <= '0;
            mqb_q     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (cnt_nx == CNT_W'(WAIT_MAX)) begin
                timeout_q <= 1'b1;
            end
            if (capture) begin
                m_q.valid <= evalid;
                m_q.wreg  <= ewreg;
                m_q.m2reg <= em2reg;
                m_q.wmem  <= ewmem;
                m_q.dest  <= edestReg;
                malu_q    <= ealu;
                mqb_q     <= eqb;
            end
        end
    end

    assign mvalid      = m_q.valid;
    assign mwreg       = m_q.wreg;
    assign mm2reg      = m_q.m2reg;
    assign mwmem       = m_q.wmem;
    assign mdestReg    = m_q.dest;
    assign malu        = malu_q;
    assign mqb         = mqb_q;
    assign mem_timeout = timeout_q;

    hazard_cmp u_cmp_rs (
        .src       (drs),
        .use_src   (duse_rs),
        .evalid    (evalid),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .edest     (edestReg),
        .mvalid    (m_q.valid),
        .mwreg     (m_q.wreg),
        .mdest     (m_q.dest),
        .e_hit     (rs_e_hit),
        .m_hit     (rs_m_hit),
        .e_is_load (rs_e_load)
    );

    hazard_cmp u_cmp_rt (
        .src       (drt),
        .use_src   (duse_rt),
        .evalid    (evalid),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .edest     (edestReg),
        .mvalid    (m_q.valid),
        .mwreg     (m_q.wreg),
        .mdest     (m_q.dest),
        .e_hit     (rt_e_hit),
        .m_hit     (rt_m_hit),
        .e_is_load (rt_e_load)
    );

    assign load_use = rs_e_load | rt_e_load;

`ifdef EXEMEM_FWD_EN
    // E is the youngest producer and wins; load results cannot be forwarded.
    always_comb begin
        fwda = FWD_RF;
        fwdb = FWD_RF;
        if (rs_e_hit) begin
            fwda = m_q.m2reg ? FWD_RF : FWD_RF;
            fwda = em2reg ? FWD_RF : FWD_E;
        end else if (rs_m_hit & ~m_q.m2reg) begin
            fwda = FWD_M;
        end
        if (rt_e_hit) begin
            fwdb = em2reg ? FWD_RF : FWD_E;
        end else if (rt_m_hit & ~m_q.m2reg) begin
            fwdb = FWD_M;
        end
    end
    assign m_load_stall = (rs_m_hit | rt_m_hit) & m_q.m2reg;
    assign nofwd_raw    = 1'b0;
`else
    assign fwda         = FWD_RF;
    assign fwdb         = FWD_RF;
    assign m_load_stall = 1'b0;
    assign nofwd_raw    = rs_e_hit | rs_m_hit | rt_e_hit | rt_m_hit;
`endif

    assign stall_id = load_use | e_hold | nofwd_raw | m_load_stall;

endmodule

// File: tb/tb_exemem_hazard_stage.sv
// Randomized bench for exemem_hazard_stage against a cycle-level behavioural model.
module tb_exemem_hazard_stage;

    localparam int unsigned DW       = 32;
    localparam int unsigned WAIT_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          evalid, ewreg, em2reg, ewmem;
    logic [4:0]    edestReg, drs, drt;
    logic [DW-1:0] ealu, eqb;
    logic          duse_rs, duse_rt, mem_rdy;
    logic          mvalid, mwreg, mm2reg, mwmem;
    logic [4:0]    mdestReg;
    logic [DW-1:0] malu, mqb;
    logic          stall_id, e_hold, mem_timeout;
    logic [1:0]    fwda, fwdb;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: contents of M, whether an access is outstanding, wait count, timeout flag.
    bit            r_v, r_w, r_l, r_s;
    int            r_d;
    logic [DW-1:0] r_alu, r_qb;
    bit            r_waiting;
    int            r_cnt;
    bit            r_tmo;

    exemem_hazard_stage #(.WAIT_MAX(WAIT_MAX), .DW(DW)) dut (
        .clk(clk), .rst(rst), .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg),
        .ewmem(ewmem), .edestReg(edestReg), .ealu(ealu), .eqb(eqb), .drs(drs),
        .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt), .mem_rdy(mem_rdy),
        .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .mdestReg(mdestReg), .malu(malu), .mqb(mqb), .stall_id(stall_id),
        .e_hold(e_hold), .fwda(fwda), .fwdb(fwdb), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit e_match(input int src, input bit use_it);
        return use_it && src != 0 && evalid && ewreg && src == int'(edestReg);
    endfunction

    function automatic bit m_match(input int src, input bit use_it);
        return use_it && src != 0 && r_v && r_w && src == r_d;
    endfunction

    // Expected forward select for one source: 0 register file, 1 E, 2 M.
    function automatic int exp_fwd(input int src, input bit use_it);
`ifdef EXEMEM_FWD_EN
        if (e_match(src, use_it)) return em2reg ? 0 : 1;
        if (m_match(src, use_it)) return r_l ? 0 : 2;
`endif
        return 0;
    endfunction

    task automatic compare_all();
        bit ea, eb, ma, mb, mem_busy, hold, lu, extra;
        ea = e_match(int'(drs), duse_rs);
        eb = e_match(int'(drt), duse_rt);
        ma = m_match(int'(drs), duse_rs);
        mb = m_match(int'(drt), duse_rt);
        mem_busy = r_v && (r_l || r_s);
        hold = r_waiting || (mem_busy && !mem_rdy);
        lu = (ea || eb) && em2reg;
`ifdef EXEMEM_FWD_EN
        extra = (ma || mb) && r_l;
`else
        extra = ea || eb || ma || mb;
`endif
        check("mvalid", 64'(mvalid), 64'(r_v));
        check("mwreg", 64'(mwreg), 64'(r_w));
        check("mm2reg", 64'(mm2reg), 64'(r_l));
        check("mwmem", 64'(mwmem), 64'(r_s));
        check("mdestReg", 64'(mdestReg), 64'(r_d));
        check("malu", 64'(malu), 64'(r_alu));
        check("mqb", 64'(mqb), 64'(r_qb));
        check("e_hold", 64'(e_hold), 64'(hold));
        check("stall_id", 64'(stall_id), 64'(lu || hold || extra));
        check("fwda", 64'(fwda), 64'(exp_fwd(int'(drs), duse_rs)));
        check("fwdb", 64'(fwdb), 64'(exp_fwd(int'(drt), duse_rt)));
        check("mem_timeout", 64'(mem_timeout), 64'(r_tmo));
    endtask

    task automatic model_update();
        bit mem_busy, still_waiting;
        if (rst) begin
            {r_v, r_w, r_l, r_s} = '0;
            r_d = 0; r_alu = '0; r_qb = '0;
            r_waiting = 0; r_cnt = 0; r_tmo = 0;
            return;
        end
        mem_busy = r_v && (r_l || r_s);
        still_waiting = r_waiting ? !mem_rdy : (mem_busy && !mem_rdy);
        if (!still_waiting) r_cnt = 0;
        else if (!r_waiting) r_cnt = 1;
        else r_cnt = (r_cnt >= 255) ? 255 : r_cnt + 1;
        if (still_waiting && r_cnt >= int'(WAIT_MAX)) r_tmo = 1;
        r_waiting = still_waiting;
        if (!still_waiting) begin
            r_v = evalid; r_w = ewreg; r_l = em2reg; r_s = ewmem;
            r_d = int'(edestReg); r_alu = ealu; r_qb = eqb;
        end
    endtask

    // Check this cycle, then advance one clock and inputs may change #1 after the edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic randomize_inputs(input int rdy_pct);
        evalid   = ($urandom_range(0, 9) != 0);
        ewreg    = $urandom_range(0, 1) == 1;
        em2reg   = $urandom_range(0, 3) == 0;
        ewmem    = !em2reg && ($urandom_range(0, 3) == 0);
        edestReg = 5'($urandom_range(0, 7));
        ealu     = DW'($urandom);
        eqb      = DW'($urandom);
        drs      = 5'($urandom_range(0, 7));
        drt      = 5'($urandom_range(0, 7));
        duse_rs  = $urandom_range(0, 3) != 0;
        duse_rt  = $urandom_range(0, 1) == 1;
        mem_rdy  = $urandom_range(0, 99) < rdy_pct;
    endtask

    task automatic drive_e(input bit l, input bit s, input bit w, input int d, input logic [DW-1:0] a);
        evalid = 1; ewreg = w; em2reg = l; ewmem = s;
        edestReg = 5'(d); ealu = a; eqb = ~a;
    endtask

    initial begin
        rst = 1;
        evalid = 0; ewreg = 0; em2reg = 0; ewmem = 0; edestReg = '0;
        ealu = '0; eqb = '0; drs = '0; drt = '0; duse_rs = 0; duse_rt = 0; mem_rdy = 1;
        @(posedge clk);
        model_update();
        #1;
        step();
        rst = 0;

        // ALU producer to r5 read by the next instruction.
        drive_e(0, 0, 1, 5, 32'h10); drs = 5; duse_rs = 1;
        step();
        evalid = 0;
        step();
        step();

        // Load to r7 followed by a consumer of r7.
        drive_e(1, 0, 1, 7, 32'h40); drs = 0; duse_rs = 0; drt = 7; duse_rt = 1;
        step();
        evalid = 0;
        step();
        step();

        // Store stalled in M long enough to trip the timeout, then released.
        drive_e(0, 1, 0, 0, 32'h80); duse_rt = 0;
        step();
        drive_e(0, 0, 1, 9, 32'h99); mem_rdy = 0;
        for (int i = 0; i < 6; i++) step();
        mem_rdy = 1;
        step();
        step();
        check("timeout_sticky", 64'(mem_timeout), 64'(1));

        // r0 never hazards; E beats M on the same register.
        drive_e(0, 0, 1, 0, 32'h5); drs = 0; duse_rs = 1;
        step();
        drive_e(0, 0, 1, 3, 32'h6); drs = 3;
        step();
        drive_e(0, 0, 1, 3, 32'h7);
        step();

        // Reset in the middle of a memory wait.
        drive_e(1, 0, 1, 4, 32'h100); duse_rs = 0;
        step();
        mem_rdy = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0; evalid = 0;
        step();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs((i / 500) % 2 == 0 ? 70 : 30);
            rst = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
